// File: rtl/ddr_port_arbiter.sv
// Four-port DDR command arbiter: two write and two read channels share one burst engine.
// Round-robin grant, command handshake, per-channel strobe routing and a BUSY watchdog.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for a request while ddr_init_done is high; winner latched on grant
// ISSUE  | cmd_valid held with latched fields until cmd_ready
// BUSY   | engine strobes routed to the granted channel; watchdog running
// DONE   | one-cycle finish pulse to the granted channel
module ddr_port_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int LEN_W   = 10,
   parameter int TIMEOUT = 4095
) (
   input  logic                  clk_ref,
   input  logic                  rst,
   input  logic                  ddr_init_done,
   input  logic [1:0]            wr_req,
   input  logic [2*ADDR_W-1:0]   wr_addr,
   input  logic [2*LEN_W-1:0]    wr_len,
   input  logic [1:0]            rd_req,
   input  logic [2*ADDR_W-1:0]   rd_addr,
   input  logic [2*LEN_W-1:0]    rd_len,
   output logic [1:0]            wr_ack,
   output logic [1:0]            rd_ack,
   output logic [1:0]            wr_finish,
   output logic [1:0]            rd_finish,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_wr,
   output logic [ADDR_W-1:0]     cmd_addr,
   output logic [LEN_W-1:0]      cmd_len,
   input  logic                  eng_wr_ack,
   input  logic                  eng_rd_ack,
   input  logic                  eng_done,
   output logic [1:0]            grant_id,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          last_grant;
   logic [1:0]          grant_q;
   logic                cmd_wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [WD_W-1:0]     wdog;
   logic                err_q;

   logic [3:0]          req_all;
   logic [1:0]          pick;
   logic [1:0]          idx;
   logic                pick_vld;
   logic [ADDR_W-1:0]   pick_addr;
   logic [LEN_W-1:0]    pick_len;
   logic                grant_en;
   logic                zero_len;
   logic                wdog_hit;
   logic                handshake;

   // bit index equals grant id: wr0, wr1, rd0, rd1
   assign req_all = {rd_req, wr_req};

   always_comb begin
      pick     = 2'd0;
      pick_vld = 1'b0;
      idx      = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_grant + 2'(i);
         if (!pick_vld && req_all[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      pick_addr = rd_addr[2*ADDR_W-1:ADDR_W];
      pick_len  = rd_len[2*LEN_W-1:LEN_W];
      case (pick)
         2'd0: begin
            pick_addr = wr_addr[ADDR_W-1:0];
            pick_len  = wr_len[LEN_W-1:0];
         end
         2'd1: begin
            pick_addr = wr_addr[2*ADDR_W-1:ADDR_W];
            pick_len  = wr_len[2*LEN_W-1:LEN_W];
         end
         2'd2: begin
            pick_addr = rd_addr[ADDR_W-1:0];
            pick_len  = rd_len[LEN_W-1:0];
         end
         default: begin
            pick_addr = rd_addr[2*ADDR_W-1:ADDR_W];
            pick_len  = rd_len[2*LEN_W-1:LEN_W];
         end
      endcase
   end

   assign grant_en  = (state == S_IDLE) && ddr_init_done && pick_vld;
   assign zero_len  = (pick_len == '0);
   assign handshake = (state == S_ISSUE) && cmd_ready;
   assign wdog_hit  = (state == S_BUSY) && (wdog == WD_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_en) state_nxt = zero_len ? S_DONE : S_ISSUE;
         S_ISSUE: if (cmd_ready) state_nxt = S_BUSY;
         S_BUSY:  if (eng_done || wdog_hit) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_ref) begin
      if (rst) begin
         state      <= S_IDLE;
         last_grant <= 2'd3;
         grant_q    <= 2'd0;
         cmd_wr_q   <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         wdog       <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_en) begin
            grant_q  <= pick;
            cmd_wr_q <= ~pick[1];
            addr_q   <= pick_addr;
            len_q    <= pick_len;
            // zero-length bursts never handshake, so rotate the pointer here
            if (zero_len) last_grant <= pick;
         end
         if (handshake) begin
            wdog       <= '0;
            last_grant <= grant_q;
         end else if (state == S_BUSY) begin
            wdog <= wdog + WD_W'(1);
         end
         // a real eng_done in the terminal cycle wins over the watchdog
         if (wdog_hit && !eng_done) err_q <= 1'b1;
      end
   end

   always_comb begin
      wr_ack    = 2'b00;
      rd_ack    = 2'b00;
      wr_finish = 2'b00;
      rd_finish = 2'b00;
      if (state == S_BUSY) begin
         if (!grant_q[1]) wr_ack[grant_q[0]] = eng_wr_ack;
         else             rd_ack[grant_q[0]] = eng_rd_ack;
      end
      if (state == S_DONE) begin
         if (!grant_q[1]) wr_finish[grant_q[0]] = 1'b1;
         else             rd_finish[grant_q[0]] = 1'b1;
      end
   end

   assign cmd_valid   = (state == S_ISSUE);
   assign cmd_wr      = cmd_wr_q;
   assign cmd_addr    = addr_q;
   assign cmd_len     = len_q;
   assign grant_id    = grant_q;
   assign busy        = (state != S_IDLE);
   assign timeout_err = err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: scoreboard queues of expected commands and finishes,
// popped by a negedge monitor; a second instance with TIMEOUT=15 exercises the watchdog.
`timescale 1ns/1ps

module tb_ddr_port_arbiter;

   typedef struct packed {
      logic        wr;
      logic [1:0]  id;
      logic [23:0] addr;
      logic [9:0]  len;
   } cmd_t;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] acks;
   } fin_t;

   logic        clk_ref = 1'b0;
   logic        rst;
   logic        ddr_init_done;
   logic [1:0]  wr_req, rd_req;
   logic [47:0] wr_addr, rd_addr;
   logic [19:0] wr_len, rd_len;
   logic        cmd_ready, eng_wr_ack, eng_rd_ack, eng_done;
   logic [1:0]  wr_ack, rd_ack, wr_finish, rd_finish, grant_id;
   logic        cmd_valid, cmd_wr, busy, timeout_err;
   logic [23:0] cmd_addr;
   logic [9:0]  cmd_len;

   logic [1:0]  to_req;
   logic [1:0]  to_wr_ack, to_rd_ack, to_wr_finish, to_rd_finish, to_grant_id;
   logic        to_cmd_valid, to_cmd_wr, to_busy, to_err;
   logic [23:0] to_cmd_addr;
   logic [9:0]  to_cmd_len;

   int checks = 0;
   int errors = 0;
   cmd_t exp_cmd[$];
   fin_t exp_fin[$];

   always #5 clk_ref = ~clk_ref;

   ddr_port_arbiter dut (
      .clk_ref(clk_ref), .rst(rst), .ddr_init_done(ddr_init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
      .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_finish(wr_finish), .rd_finish(rd_finish),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .eng_wr_ack(eng_wr_ack), .eng_rd_ack(eng_rd_ack), .eng_done(eng_done),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   ddr_port_arbiter #(.TIMEOUT(15)) dut_to (
      .clk_ref(clk_ref), .rst(rst), .ddr_init_done(1'b1),
      .wr_req(to_req), .wr_addr(48'h0), .wr_len({10'd0, 10'd4}),
      .rd_req(2'b00), .rd_addr(48'h0), .rd_len(20'h0),
      .wr_ack(to_wr_ack), .rd_ack(to_rd_ack), .wr_finish(to_wr_finish), .rd_finish(to_rd_finish),
      .cmd_valid(to_cmd_valid), .cmd_ready(1'b1), .cmd_wr(to_cmd_wr),
      .cmd_addr(to_cmd_addr), .cmd_len(to_cmd_len),
      .eng_wr_ack(1'b0), .eng_rd_ack(1'b0), .eng_done(1'b0),
      .grant_id(to_grant_id), .busy(to_busy), .timeout_err(to_err)
   );

   logic [47:0] outs_all;
   assign outs_all = {cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_ack, rd_ack,
                      wr_finish, rd_finish, busy, grant_id, timeout_err};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_ref);
      #1;
   endtask

   task automatic wait_cmd(input int bound, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk_ref);
         if (cmd_valid && cmd_ready) begin
            hit = 1'b1;
            break;
         end
      end
      chk(name, 64'(hit), 64'd1);
      @(posedge clk_ref);
      #1;
   endtask

   // mode 0: strobes only, 1: eng_done with the last strobe, 2: eng_done one cycle after
   task automatic drive_eng(input int n, input bit wr, input int mode);
      for (int i = 0; i < n; i++) begin
         eng_wr_ack = wr;
         eng_rd_ack = !wr;
         eng_done   = (mode == 1) && (i == n - 1);
         tick(1);
      end
      eng_wr_ack = 1'b0;
      eng_rd_ack = 1'b0;
      eng_done   = 1'b0;
      if (mode == 2) begin
         eng_done = 1'b1;
         tick(1);
         eng_done = 1'b0;
      end
   endtask

   task automatic push_cmd(input logic [1:0] id, input logic [23:0] addr, input logic [9:0] len);
      exp_cmd.push_back('{wr: ~id[1], id: id, addr: addr, len: len});
   endtask

   task automatic push_fin(input logic [1:0] id, input int acks);
      exp_fin.push_back('{id: id, acks: 16'(acks)});
   endtask

   // monitor
   int   ack_cnt[4];
   int   ack_tot;
   cmd_t mon_c;
   fin_t mon_f;
   logic [3:0] fvec, fin_prev;

   always @(negedge clk_ref) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
         fin_prev = 4'b0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
            if (exp_cmd.size() == 0) begin
               chk("cmd_unexpected", 64'd1, 64'd0);
            end else begin
               mon_c = exp_cmd.pop_front();
               chk("cmd_fields", 64'({cmd_wr, grant_id, cmd_addr, cmd_len}), 64'(mon_c));
            end
         end
         if (wr_ack[0]) ack_cnt[0]++;
         if (wr_ack[1]) ack_cnt[1]++;
         if (rd_ack[0]) ack_cnt[2]++;
         if (rd_ack[1]) ack_cnt[3]++;
         fvec = {rd_finish, wr_finish};
         if (fvec != 4'b0) begin
            chk("finish_single", 64'(fin_prev), 64'd0);
            if (exp_fin.size() == 0) begin
               chk("finish_unexpected", 64'(fvec), 64'd0);
            end else begin
               mon_f = exp_fin.pop_front();
               chk("finish_onehot", 64'(fvec), 64'(4'b0001 << mon_f.id));
               chk("ack_count", 64'(ack_cnt[mon_f.id]), 64'(mon_f.acks));
               ack_tot = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
               chk("stray_acks", 64'(ack_tot - ack_cnt[mon_f.id]), 64'd0);
            end
            for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
         end
         fin_prev = fvec;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [9:0]  rr_len [5];
      logic [23:0] rr_addr[5];
      logic [1:0]  rr_id  [5];
      bit          seen;

      rst = 1'b1; ddr_init_done = 1'b1; wr_req = 2'b11; rd_req = 2'b00;
      wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
      cmd_ready = 1'b1; eng_wr_ack = 1'b1; eng_rd_ack = 1'b0; eng_done = 1'b0; to_req = 2'b00;
      tick(2);
      chk("reset_outputs", 64'(outs_all), 64'd0);
      chk("reset_to_err", 64'(to_err), 64'd0);
      wr_req = 2'b00; eng_wr_ack = 1'b0; cmd_ready = 1'b0;
      rst = 1'b0;
      tick(1);
      chk("idle_after_reset", 64'(outs_all), 64'd0);

      // single write burst of 256
      cmd_ready = 1'b1;
      wr_addr[23:0] = 24'h000100; wr_len[9:0] = 10'd256;
      push_cmd(2'd0, 24'h000100, 10'd256);
      push_fin(2'd0, 256);
      wr_req = 2'b01;
      wait_cmd(2, "wr0_cmd_latency");
      wr_req = 2'b00;
      drive_eng(256, 1'b1, 2);
      tick(3);

      // cmd_ready stalled for 10 cycles; request withdrawn and stray engine strobes present
      cmd_ready = 1'b0;
      rd_addr[47:24] = 24'h0ABCDE; rd_len[19:10] = 10'd5;
      push_cmd(2'd3, 24'h0ABCDE, 10'd5);
      push_fin(2'd3, 5);
      rd_req = 2'b10;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_ref);
         if (cmd_valid) begin seen = 1'b1; break; end
      end
      chk("rd1_cmd_valid", 64'(seen), 64'd1);
      @(posedge clk_ref); #1;
      rd_req = 2'b00;
      eng_wr_ack = 1'b1; eng_rd_ack = 1'b1; eng_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_ref);
         chk("stall_hold", 64'({cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_ack, rd_ack, busy, grant_id}),
             64'({1'b1, 1'b0, 24'h0ABCDE, 10'd5, 2'b00, 2'b00, 1'b1, 2'd3}));
      end
      @(posedge clk_ref); #1;
      eng_wr_ack = 1'b0; eng_rd_ack = 1'b0; eng_done = 1'b0;
      cmd_ready = 1'b1;
      wait_cmd(2, "rd1_handshake");
      drive_eng(5, 1'b0, 1);
      tick(3);

      // all four requesting: round robin 0,1,2,3,0
      rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_len  = '{10'd2, 10'd3, 10'd4, 10'd1, 10'd2};
      rr_addr = '{24'h000010, 24'h000020, 24'h000030, 24'h000040, 24'h000010};
      wr_addr = {24'h000020, 24'h000010}; wr_len = {10'd3, 10'd2};
      rd_addr = {24'h000040, 24'h000030}; rd_len = {10'd1, 10'd4};
      for (int i = 0; i < 5; i++) begin
         push_cmd(rr_id[i], rr_addr[i], rr_len[i]);
         push_fin(rr_id[i], int'(rr_len[i]));
      end
      wr_req = 2'b11; rd_req = 2'b11;
      for (int i = 0; i < 5; i++) begin
         wait_cmd(5, "rr_cmd");
         if (i == 4) begin wr_req = 2'b00; rd_req = 2'b00; end
         drive_eng(int'(rr_len[i]), !rr_id[i][1], 2);
      end
      tick(3);

      // grants blocked until calibration completes
      ddr_init_done = 1'b0;
      wr_addr[47:24] = 24'h000055; wr_len[19:10] = 10'd7;
      wr_req = 2'b10;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("no_grant_uncal", 64'({cmd_valid, busy}), 64'd0);
      end
      push_cmd(2'd1, 24'h000055, 10'd7);
      push_fin(2'd1, 7);
      ddr_init_done = 1'b1;
      wait_cmd(2, "grant_after_cal");
      wr_req = 2'b00;
      drive_eng(7, 1'b1, 2);
      tick(3);

      // watchdog on the TIMEOUT=15 instance
      to_req = 2'b01;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_ref);
         if (to_cmd_valid) begin seen = 1'b1; break; end
      end
      chk("to_cmd_valid", 64'(seen), 64'd1);
      @(posedge clk_ref); #1;
      to_req = 2'b00;
      tick(14);
      chk("to_busy_cycle15", 64'({to_busy, to_err, to_wr_finish}), 64'({1'b1, 1'b0, 2'b00}));
      tick(1);
      chk("to_done", 64'({to_busy, to_err, to_wr_finish}), 64'({1'b1, 1'b1, 2'b01}));
      tick(1);
      chk("to_idle_sticky", 64'({to_busy, to_err, to_wr_finish}), 64'({1'b0, 1'b1, 2'b00}));

      // reset in the middle of a burst
      wr_addr[23:0] = 24'h000777; wr_len[9:0] = 10'd20;
      push_cmd(2'd0, 24'h000777, 10'd20);
      wr_req = 2'b01;
      wait_cmd(2, "mid_rst_cmd");
      wr_req = 2'b00;
      eng_wr_ack = 1'b1;
      tick(3);
      chk("busy_ack_route", 64'({wr_ack, rd_ack}), 64'({2'b01, 2'b00}));
      rst = 1'b1;
      tick(1);
      chk("mid_rst_outputs", 64'(outs_all), 64'd0);
      chk("mid_rst_to_err", 64'(to_err), 64'd0);
      rst = 1'b0;
      tick(3);
      chk("idle_ignores_strobe", 64'(outs_all), 64'd0);
      eng_wr_ack = 1'b0;

      // zero-length read on rd0
      rd_addr[23:0] = 24'h000999; rd_len[9:0] = 10'd0;
      push_fin(2'd2, 0);
      rd_req = 2'b01;
      tick(1);
      rd_req = 2'b00;
      chk("zero_len_finish", 64'({cmd_valid, rd_finish, busy}), 64'({1'b0, 2'b01, 1'b1}));
      tick(1);
      chk("zero_len_idle", 64'({cmd_valid, rd_finish, busy}), 64'd0);
      tick(4);

      chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
      chk("fin_queue_drained", 64'(exp_fin.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, DDR word address width.
REQ-002 SHALL have parameter LEN_W, default 10, burst length width.
REQ-003 SHALL have parameter TIMEOUT, default 4095, max cycles from command acceptance to eng_done.
REQ-004 SHALL have one clock, clk_ref; reset is synchronous and active-high.
REQ-005 clk_ref  in  1  single clock for all logic.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ddr_init_done  in  1  DDR calibrated; grants are allowed only when high.
REQ-008 wr_req  in  2  write burst request, one bit per write channel (ch0, ch1).
REQ-009 wr_addr  in  2*ADDR_W  {ch1,ch0} write start addresses.
REQ-010 wr_len  in  2*LEN_W  {ch1,ch0} write burst lengths.
REQ-011 rd_req / rd_addr / rd_len  in  2 / 2*ADDR_W / 2*LEN_W  read equivalents.
REQ-012 wr_ack, rd_ack  out  2 each  per-channel data strobe (FIFO rd_en / wr_en).
REQ-013 wr_finish, rd_finish  out  2 each  per-channel one-cycle burst-complete pulse.
REQ-014 cmd_valid  out  1; cmd_ready  in  1  command handshake to the DDR burst engine.
REQ-015 cmd_wr  out  1 (1=write); cmd_addr  out  ADDR_W; cmd_len  out  LEN_W.
REQ-016 eng_wr_ack, eng_rd_ack, eng_done  in  1 each  engine data strobes and burst-end pulse.
REQ-017 grant_id  out  2 (0=wr0, 1=wr1, 2=rd0, 3=rd1); busy  out  1; timeout_err  out  1 (sticky).

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, BUSY, DONE.
REQ-019 IDLE: with ddr_init_done=1 and any request {rd_req,wr_req} set, SHALL pick a winner round-robin, searching from last_grant+1 mod 4, latch its id/addr/len, and go to ISSUE next cycle.
REQ-020 IDLE with ddr_init_done=0: SHALL stay IDLE; requests are ignored.
REQ-021 ISSUE: cmd_valid=1 with latched cmd_wr/addr/len held stable; on cmd_valid&cmd_ready, SHALL go to BUSY, clear the watchdog, and update last_grant.
REQ-022 BUSY: wr_ack[id]=eng_wr_ack (write grant) or rd_ack[id]=eng_rd_ack (read grant), combinational, same cycle; all other ack bits SHALL be 0.
REQ-023 BUSY: on eng_done, SHALL go to DONE; the engine strobe in that same cycle is still routed.
REQ-024 DONE: SHALL pulse wr_finish[id] or rd_finish[id] for exactly one cycle, then go to IDLE; a request still high in the IDLE cycle is eligible again.
REQ-025 Zero-length request (len=0): winner SHALL go directly IDLE->DONE with no cmd_valid; finish pulse still issued.
REQ-026 Watchdog: counter SHALL increment each BUSY cycle; on reaching TIMEOUT, set timeout_err=1, go to DONE, and issue the finish pulse; timeout_err clears only on rst.
REQ-027 Engine strobes and eng_done outside BUSY SHALL be ignored.
REQ-028 A request deasserted while in ISSUE SHALL NOT cancel the command.
REQ-029 busy SHALL be 1 in ISSUE, BUSY, DONE; grant_id holds the latched winner.

Reset
REQ-030 On rst=1 at a clk_ref edge: state=IDLE, last_grant=3 (ch wr0 is searched first), and cmd_valid, cmd_wr, cmd_addr, cmd_len, all ack/finish bits, busy, grant_id and timeout_err SHALL all be 0.
REQ-031 rst mid-burst SHALL abandon the grant immediately, with no finish pulse.

Verification
REQ-032 Single write: wr_req=01, wr_addr0=0x000100, wr_len0=256, cmd_ready=1 -> cmd_valid 2 cycles after req, cmd_wr=1, addr=0x000100, len=256; 256 eng_wr_ack -> 256 wr_ack[0]; eng_done -> wr_finish[0] one cycle later.
REQ-033 All four requesting continuously -> grant order 0,1,2,3,0 with no channel granted twice consecutively.
REQ-034 cmd_ready held low 10 cycles -> cmd_valid and fields stable for all 10 cycles; no acks are routed.
REQ-035 TIMEOUT=15, no eng_done -> timeout_err=1 after 15 BUSY cycles, finish pulsed, arbiter returns to IDLE.
REQ-036 ddr_init_done=0 with requests -> no cmd_valid; raise ddr_init_done -> grant 2 cycles later.
REQ-037 rst asserted during BUSY -> all outputs 0 next cycle, no finish; rd_len0=0 request -> rd_finish[0] with no cmd_valid.
